lc3_mem_arbiter: RTL

LC3_MEM_ARBITER -- requirements
Module: lc3_mem_arbiter

---
 rtl/lc3_pkg.sv | 34 +++
 rtl/lc3_rr_select.sv | 44 ++++
 rtl/lc3_mem_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// ---------------------------------------------------------------------------
// lc3_pkg -- definitions shared by the LC-3 memory arbiter files.
//   * lc3_state_e        : arbiter FSM states (IDLE, ACCESS, DONE)
//   * LC3_* localparams  : default parameter values for the arbiter
//   * lc3_onehot_to_idx  : converts a one-hot vector (up to 8 bits) to an index
// ---------------------------------------------------------------------------
package lc3_pkg;

    localparam int LC3_NUM_REQ = 2;
    localparam int LC3_ADDR_W  = 16;
    localparam int LC3_DATA_W  = 16;
    localparam int LC3_MEM_LAT = 2;
    // Wait counter width; enough for the largest supported latency of 15.
    localparam int LC3_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lc3_state_e;

    // Index of the set bit of a one-hot vector; returns 0 for an all-zero input.
    function automatic logic [2:0] lc3_onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lc3_rr_select.sv
// ---------------------------------------------------------------------------
// lc3_rr_select -- combinational round-robin selector.
// Scans upward from (last_winner + 1) mod NUM_REQ and returns the first
// requesting channel as a one-hot vector (all zero when nothing requests).
//   req         in  NUM_REQ  per-channel request
//   last_winner in  IDX_W    index of the channel served last
//   winner      out NUM_REQ  one-hot winning channel
// ---------------------------------------------------------------------------
module lc3_rr_select
    import lc3_pkg::*;
#(
    parameter int NUM_REQ = LC3_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] winner
);

    int   idx_s;
    logic found_s;

    // Rotating priority scan; the wrap is a subtract since idx_s < 2*NUM_REQ.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = int'(last_winner) + k;
            if (idx_s >= NUM_REQ) begin
                idx_s = idx_s - NUM_REQ;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s]) begin
                winner[idx_s] = 1'b1;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lc3_mem_arbiter -- round-robin arbiter giving NUM_REQ channels access to a
// single fixed-latency memory (channel 0 = instruction fetch, 1 = data).
// Each access: IDLE (arbitrate) -> MEM_LAT x ACCESS -> DONE (complete pulse).
//   clk, reset          clock, asynchronous active-low reset
//   req/rd              per-channel request and direction (1 = read)
//   addr/wdata          packed per-channel address / write data
//   grant               one-hot owner of the memory (registered)
//   complete            one-cycle per-channel completion pulse
//   rdata               last read data, valid with its complete pulse
//   mem_en/mem_rd       memory enable and direction
//   mem_addr/mem_din    memory address and write data
//   mem_dout            memory read data
// ---------------------------------------------------------------------------
module lc3_mem_arbiter
    import lc3_pkg::*;
#(
    parameter int NUM_REQ = LC3_NUM_REQ,
    parameter int ADDR_W  = LC3_ADDR_W,
    parameter int DATA_W  = LC3_DATA_W,
    parameter int MEM_LAT = LC3_MEM_LAT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        rd,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        complete,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic                      mem_rd,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout
);

    localparam int                   IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]     LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [LC3_CNT_W-1:0] CNT_LOAD = LC3_CNT_W'(MEM_LAT - 1);
    localparam logic [LC3_CNT_W-1:0] CNT_ONE  = LC3_CNT_W'(1);

    lc3_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   complete_q, complete_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_din_q, mem_din_d;
    logic [LC3_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]     last_winner_q, last_winner_d;

    logic [NUM_REQ-1:0]   winner_s;
    logic                 win_rd_s;
    logic [ADDR_W-1:0]    win_addr_s;
    logic [DATA_W-1:0]    win_wdata_s;
    logic [2:0]           grant_idx_s;

    lc3_rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req         (req),
        .last_winner (last_winner_q),
        .winner      (winner_s)
    );

    // Index of the channel currently holding the grant, used to update last_winner.
    always_comb begin
        grant_idx_s = lc3_onehot_to_idx(8'(grant_q));
    end

    // AND-OR mux of the winning channel's fields; winner_s is one-hot or zero.
    always_comb begin
        win_rd_s    = 1'b0;
        win_addr_s  = '0;
        win_wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_rd_s    = win_rd_s    | (rd[i] & winner_s[i]);
            win_addr_s  = win_addr_s  | (addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{winner_s[i]}});
            win_wdata_s = win_wdata_s | (wdata[i*DATA_W +: DATA_W] & {DATA_W{winner_s[i]}});
        end
    end

    // FSM next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        complete_d    = '0;
        rdata_d       = rdata_q;
        mem_en_d      = mem_en_q;
        mem_rd_d      = mem_rd_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        cnt_d         = cnt_q;
        last_winner_d = last_winner_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d    = ST_ACCESS;
                    grant_d    = winner_s;
                    mem_en_d   = 1'b1;
                    mem_rd_d   = win_rd_s;
                    mem_addr_d = win_addr_s;
                    mem_din_d  = win_wdata_s;
                    cnt_d      = CNT_LOAD;
                end else begin
                    grant_d  = '0;
                    mem_en_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    // Last wait cycle: memory data is valid now, so capture it.
                    state_d    = ST_DONE;
                    mem_en_d   = 1'b0;
                    complete_d = grant_q;
                    if (mem_rd_q) begin
                        rdata_d = mem_dout;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d       = ST_IDLE;
                grant_d       = '0;
                last_winner_d = grant_idx_s[IDX_W-1:0];
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                mem_en_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            complete_q    <= '0;
            rdata_q       <= '0;
            mem_en_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            cnt_q         <= '0;
            last_winner_q <= LAST_RST;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            complete_q    <= complete_d;
            rdata_q       <= rdata_d;
            mem_en_q      <= mem_en_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            cnt_q         <= cnt_d;
            last_winner_q <= last_winner_d;
        end
    end

    assign grant    = grant_q;
    assign complete = complete_q;
    assign rdata    = rdata_q;
    assign mem_en   = mem_en_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule
